// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

    // Default register address width for a 32-entry register file
    localparam int AW_DEF = 5;

    // EX-stage operand mux select codes
    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Controller run state
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Single-operand forwarding comparator: picks the youngest in-flight producer.
// Latency: combinational, zero cycles.
// Backpressure: none; i_en low forces the IDEX (no-forward) code.
module fwd_sel
    import pipe_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          i_en,
    input  logic [AW-1:0] i_rs,
    input  logic [AW-1:0] i_mem_rd,
    input  logic          i_mem_we,
    input  logic [AW-1:0] i_wb_rd,
    input  logic          i_wb_we,
    output logic [1:0]    o_sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    // Register 0 is hardwired to zero, so a write to it never forwards
    assign w_mem_hit = i_mem_we && (i_mem_rd != '0) && (i_mem_rd == i_rs);
    assign w_wb_hit  = i_wb_we  && (i_wb_rd  != '0) && (i_wb_rd  == i_rs);

    // EXMEM holds the younger result, so it takes precedence over MEMWB
    always_comb begin
        o_sel = FWD_NONE;
        if (i_en) begin
            if (w_mem_hit) begin
                o_sel = FWD_EXMEM;
            end else if (w_wb_hit) begin
                o_sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: stalls, flushes, freezes and operand selects for a 5-stage pipe.
// Latency: control outputs combinational from registered state; state/counters update on clk_i.
// Backpressure: a data-memory wait freezes the whole pipe and masks branch and load-use actions.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int NSRC    = 2,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [NSRC*AW-1:0]   id_rs_i,
    input  logic [NSRC-1:0]      id_use_i,
    input  logic [NSRC*AW-1:0]   ex_rs_i,
    input  logic [AW-1:0]        ex_rd_i,
    input  logic [AW-1:0]        mem_rd_i,
    input  logic [AW-1:0]        wb_rd_i,
    input  logic                 ex_regwrite_i,
    input  logic                 mem_regwrite_i,
    input  logic                 wb_regwrite_i,
    input  logic                 ex_memread_i,
    input  logic                 branch_taken_i,
    input  logic                 dmem_req_i,
    input  logic                 dmem_ready_i,
    output logic [2*NSRC-1:0]    fwd_o,
    output logic [NSRC-1:0]      id_wbfwd_o,
    output logic                 pc_en_o,
    output logic                 ifid_en_o,
    output logic                 freeze_o,
    output logic                 ifid_flush_o,
    output logic                 idex_flush_o,
    output logic                 exmem_flush_o,
    output logic                 err_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o
);

    localparam int               WCW     = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0]   TO_V    = WCW'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WCW-1:0]   r_wcnt;
    logic [WCW-1:0]   w_wcnt_nxt;
    logic             r_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_active;
    logic             w_mem_wait;
    logic             w_lu_hit;
    logic             w_load_use;
    logic [NSRC-1:0]  w_id_wbfwd;
    logic             w_br_flush;

    // EX-stage RegWrite does not affect any decision here; results are
    // only forwarded once they reach EXMEM or MEMWB.
    logic             w_unused;
    assign w_unused = ex_regwrite_i;

    assign w_active = (r_state != IDLE);

    // Once waiting, the access is outstanding until ready, regardless of req
    assign w_mem_wait = (dmem_req_i || (r_state == MEMWAIT)) && !dmem_ready_i;

    // One forwarding comparator per EX operand
    for (genvar k = 0; k < NSRC; k++) begin : g_fwd
        fwd_sel #(
            .AW (AW)
        ) u_fwd_sel (
            .i_en     (w_active),
            .i_rs     (ex_rs_i[k*AW +: AW]),
            .i_mem_rd (mem_rd_i),
            .i_mem_we (mem_regwrite_i),
            .i_wb_rd  (wb_rd_i),
            .i_wb_we  (wb_regwrite_i),
            .o_sel    (fwd_o[2*k +: 2])
        );
    end

    // ID-stage dependency checks: WB write-through and load-use against IDEX load
    always_comb begin
        w_id_wbfwd = '0;
        w_lu_hit   = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == id_rs_i[k*AW +: AW])) begin
                w_id_wbfwd[k] = 1'b1;
            end
            if (id_use_i[k] && (ex_rd_i == id_rs_i[k*AW +: AW])) begin
                w_lu_hit = 1'b1;
            end
        end
        w_load_use = ex_memread_i && (ex_rd_i != '0) && w_lu_hit;
    end

    // Next state and pipeline control, priority: memory wait > branch > load-use
    always_comb begin
        w_state_nxt   = r_state;
        pc_en_o       = 1'b0;
        ifid_en_o     = 1'b0;
        freeze_o      = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        id_wbfwd_o    = '0;
        w_br_flush    = 1'b0;

        case (r_state)
            IDLE:    if (start_i)      w_state_nxt = RUN;
            RUN:     if (w_mem_wait)   w_state_nxt = MEMWAIT;
            MEMWAIT: if (dmem_ready_i) w_state_nxt = RUN;
            default:                   w_state_nxt = IDLE;
        endcase
        if (!start_i) begin
            w_state_nxt = IDLE;
        end

        if (w_active) begin
            id_wbfwd_o = w_id_wbfwd;
            if (w_mem_wait) begin
                // Hold everything; branch/load-use are seen again once ready
                freeze_o = 1'b1;
            end else if (branch_taken_i) begin
                // Squash the three younger instructions and load the target PC
                freeze_o      = 1'b0;
                pc_en_o       = 1'b1;
                ifid_en_o     = 1'b1;
                ifid_flush_o  = 1'b1;
                idex_flush_o  = 1'b1;
                exmem_flush_o = 1'b1;
                w_br_flush    = 1'b1;
            end else if (w_load_use) begin
                // Hold PC/IFID one cycle and send a bubble down into EX
                freeze_o     = 1'b0;
                idex_flush_o = 1'b1;
            end else begin
                freeze_o  = 1'b0;
                pc_en_o   = 1'b1;
                ifid_en_o = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Wait-cycle count, saturating at TIMEOUT so it can never wrap
    assign w_wcnt_nxt = (r_wcnt == TO_V) ? r_wcnt : r_wcnt + 1'b1;

    // Watchdog: count stalled MEMWAIT cycles, restart on each new wait
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wcnt <= '0;
        end else if (w_state_nxt == IDLE) begin
            r_wcnt <= '0;
        end else if ((r_state != MEMWAIT) && (w_state_nxt == MEMWAIT)) begin
            r_wcnt <= '0;
        end else if ((r_state == MEMWAIT) && !dmem_ready_i) begin
            r_wcnt <= w_wcnt_nxt;
        end
    end

    // Sticky timeout error; the FSM keeps waiting, only reset clears it
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_err <= 1'b0;
        end else if ((r_state == MEMWAIT) && !dmem_ready_i && (w_wcnt_nxt == TO_V)) begin
            r_err <= 1'b1;
        end
    end

    // Saturating stall counter: any active cycle with the PC held
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if (w_active && !pc_en_o && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // Saturating flush counter: cycles where a taken branch squashes the pipe
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_flush_cnt <= '0;
        end else if (w_br_flush && (r_flush_cnt != CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign err_o       = r_err;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazards followed by random traffic.
// Latency: expected responses are queued at stimulus time and popped on the falling edge.
// Backpressure: n/a; one expected record per clock cycle.
module tb_pipe_hazard_ctrl;

    localparam int AW      = 5;
    localparam int NSRC    = 2;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int SAT     = (1 << CNT_W) - 1;

    typedef struct packed {
        logic               rst;
        logic               start;
        logic [NSRC*AW-1:0] id_rs;
        logic [NSRC-1:0]    id_use;
        logic [NSRC*AW-1:0] ex_rs;
        logic [AW-1:0]      ex_rd;
        logic [AW-1:0]      mem_rd;
        logic [AW-1:0]      wb_rd;
        logic               ex_rw;
        logic               mem_rw;
        logic               wb_rw;
        logic               memread;
        logic               br;
        logic               req;
        logic               rdy;
    } stim_t;

    typedef struct packed {
        logic [2*NSRC-1:0] fwd;
        logic [NSRC-1:0]   wbfwd;
        logic              pc;
        logic              ifid;
        logic              frz;
        logic              f_ifid;
        logic              f_idex;
        logic              f_exmem;
        logic              err;
        logic [CNT_W-1:0]  sc;
        logic [CNT_W-1:0]  fc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    stim_t cur = '0;

    logic [2*NSRC-1:0] fwd_o;
    logic [NSRC-1:0]   id_wbfwd_o;
    logic              pc_en_o, ifid_en_o, freeze_o;
    logic              ifid_flush_o, idex_flush_o, exmem_flush_o, err_o;
    logic [CNT_W-1:0]  stall_cnt_o, flush_cnt_o;

    pipe_hazard_ctrl #(
        .AW (AW), .NSRC (NSRC), .TIMEOUT (TIMEOUT), .CNT_W (CNT_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (cur.rst),
        .start_i        (cur.start),
        .id_rs_i        (cur.id_rs),
        .id_use_i       (cur.id_use),
        .ex_rs_i        (cur.ex_rs),
        .ex_rd_i        (cur.ex_rd),
        .mem_rd_i       (cur.mem_rd),
        .wb_rd_i        (cur.wb_rd),
        .ex_regwrite_i  (cur.ex_rw),
        .mem_regwrite_i (cur.mem_rw),
        .wb_regwrite_i  (cur.wb_rw),
        .ex_memread_i   (cur.memread),
        .branch_taken_i (cur.br),
        .dmem_req_i     (cur.req),
        .dmem_ready_i   (cur.rdy),
        .fwd_o          (fwd_o),
        .id_wbfwd_o     (id_wbfwd_o),
        .pc_en_o        (pc_en_o),
        .ifid_en_o      (ifid_en_o),
        .freeze_o       (freeze_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_flush_o   (idex_flush_o),
        .exmem_flush_o  (exmem_flush_o),
        .err_o          (err_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    exp_t sbq[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc_no  = 0;

    // Reference model: running/waiting flags plus plain integer counts
    bit m_run = 0, m_wait = 0, m_err = 0;
    int m_wcnt = 0, m_stall = 0, m_flush = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc_no, act, req);
    endtask

    function automatic logic [NSRC*AW-1:0] pair(input int a1, input int a0);
        logic [AW-1:0] h, l;
        h = AW'(a1);
        l = AW'(a0);
        return {h, l};
    endfunction

    // Apply one cycle of stimulus, predict the response and queue it
    task automatic cyc(input stim_t st);
        exp_t e;
        logic [AW-1:0] ers, irs;
        bit waiting, lu, brf;
        @(posedge clk);
        #1;
        cur = st;
        e = '0;
        e.frz = 1'b1;
        if (!st.rst) begin
            m_run = 0; m_wait = 0; m_err = 0;
            m_wcnt = 0; m_stall = 0; m_flush = 0;
            sbq.push_back(e);
            return;
        end
        e.err = m_err;
        e.sc  = CNT_W'(m_stall);
        e.fc  = CNT_W'(m_flush);
        brf   = 0;
        if (m_run) begin
            lu = 0;
            for (int k = 0; k < NSRC; k++) begin
                ers = st.ex_rs[k*AW +: AW];
                irs = st.id_rs[k*AW +: AW];
                if (st.mem_rw && st.mem_rd != 0 && st.mem_rd == ers)    e.fwd[2*k +: 2] = 2'b01;
                else if (st.wb_rw && st.wb_rd != 0 && st.wb_rd == ers)  e.fwd[2*k +: 2] = 2'b10;
                e.wbfwd[k] = st.wb_rw && st.wb_rd != 0 && st.wb_rd == irs;
                if (st.id_use[k] && st.ex_rd == irs) lu = 1;
            end
            lu = lu && st.memread && st.ex_rd != 0;
            waiting = (st.req || m_wait) && !st.rdy;
            if (waiting) begin
                e.frz = 1;
            end else if (st.br) begin
                e.frz = 0; e.pc = 1; e.ifid = 1;
                e.f_ifid = 1; e.f_idex = 1; e.f_exmem = 1;
                brf = 1;
            end else if (lu) begin
                e.frz = 0; e.f_idex = 1;
            end else begin
                e.frz = 0; e.pc = 1; e.ifid = 1;
            end
            if (!e.pc && m_stall < SAT) m_stall++;
            if (brf && m_flush < SAT)   m_flush++;
            if (m_wait && !st.rdy) begin
                m_wcnt++;
                if (m_wcnt >= TIMEOUT) m_err = 1;
            end
        end
        if (!st.start) begin
            m_run = 0; m_wait = 0; m_wcnt = 0;
        end else if (!m_run) begin
            m_run = 1;
        end else if (!m_wait && st.req && !st.rdy) begin
            m_wait = 1; m_wcnt = 0;
        end else if (m_wait && st.rdy) begin
            m_wait = 0;
        end
        sbq.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the queued prediction each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                cyc_no++;
                chk("fwd",        32'(fwd_o),         32'(e.fwd));
                chk("id_wbfwd",   32'(id_wbfwd_o),    32'(e.wbfwd));
                chk("pc_en",      32'(pc_en_o),       32'(e.pc));
                chk("ifid_en",    32'(ifid_en_o),     32'(e.ifid));
                chk("freeze",     32'(freeze_o),      32'(e.frz));
                chk("ifid_flush", 32'(ifid_flush_o),  32'(e.f_ifid));
                chk("idex_flush", 32'(idex_flush_o),  32'(e.f_idex));
                chk("exmem_flush",32'(exmem_flush_o), 32'(e.f_exmem));
                chk("err",        32'(err_o),         32'(e.err));
                chk("stall_cnt",  32'(stall_cnt_o),   32'(e.sc));
                chk("flush_cnt",  32'(flush_cnt_o),   32'(e.fc));
            end
        end
    end

    // Stimulus: directed hazard scenarios, then randomized traffic
    initial begin
        stim_t s;
        s = '0;
        cyc(s); cyc(s);                        // held in reset
        s.rst = 1;  cyc(s);                    // idle, not started
        s.start = 1; cyc(s);                   // IDLE -> RUN

        // Forwarding priority
        s.ex_rs = pair(0, 3);
        s.mem_rd = 3; s.mem_rw = 1; s.wb_rd = 3; s.wb_rw = 1; cyc(s);
        s.mem_rw = 0; cyc(s);
        s.mem_rw = 1; s.mem_rd = 0; s.wb_rd = 0; s.ex_rs = pair(0, 0); cyc(s);
        s.wb_rd = 7; s.id_rs = pair(7, 2); cyc(s);   // WB write-through to ID
        s.mem_rw = 0; s.wb_rw = 0; s.wb_rd = 0;

        // Load-use, then the same with the operand unused
        s.memread = 1; s.ex_rd = 5; s.id_rs = pair(5, 0); s.id_use = 2'b10; cyc(s);
        s.memread = 0; s.wb_rw = 1; s.wb_rd = 5; s.ex_rs = pair(5, 0); cyc(s);
        s.wb_rw = 0; s.wb_rd = 0; s.ex_rs = '0;
        s.memread = 1; s.id_use = 2'b00; cyc(s);
        s.memread = 0;

        // Taken branch for one cycle
        s.br = 1; cyc(s);
        s.br = 0; cyc(s);

        // Memory wait with a coinciding load-use
        s.memread = 1; s.id_use = 2'b10;
        s.req = 1; s.rdy = 0; cyc(s); cyc(s); cyc(s);
        s.rdy = 1; cyc(s);
        s.req = 0; s.rdy = 0; s.memread = 0; cyc(s);

        // Watchdog timeout, persists across a start toggle
        s.req = 1; s.rdy = 0;
        for (int i = 0; i < 6; i++) cyc(s);
        s.rdy = 1; cyc(s);
        s.req = 0; s.rdy = 0;
        s.start = 0; cyc(s);
        s.start = 1; cyc(s); cyc(s);

        // Stall counter saturation, then asynchronous reset mid-run
        s.memread = 1; s.ex_rd = 5; s.id_rs = pair(5, 0); s.id_use = 2'b10;
        for (int i = 0; i < 20; i++) cyc(s);
        s.rst = 0; cyc(s);
        s.rst = 1; s.memread = 0; cyc(s); cyc(s);

        // Randomized traffic over a small address space so hazards are frequent
        for (int i = 0; i < 1500; i++) begin
            s.rst     = ($urandom_range(0, 299) != 0);
            s.start   = ($urandom_range(0, 59) != 0);
            s.id_rs   = pair($urandom_range(0, 3), $urandom_range(0, 3));
            s.ex_rs   = pair($urandom_range(0, 3), $urandom_range(0, 3));
            s.id_use  = NSRC'($urandom_range(0, 3));
            s.ex_rd   = AW'($urandom_range(0, 3));
            s.mem_rd  = AW'($urandom_range(0, 3));
            s.wb_rd   = AW'($urandom_range(0, 3));
            s.ex_rw   = 1'($urandom_range(0, 1));
            s.mem_rw  = 1'($urandom_range(0, 1));
            s.wb_rw   = 1'($urandom_range(0, 1));
            s.memread = ($urandom_range(0, 3) == 0);
            s.br      = ($urandom_range(0, 7) == 0);
            s.req     = ($urandom_range(0, 3) == 0);
            s.rdy     = ($urandom_range(0, 2) == 0);
            cyc(s);
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drain", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end

endmodule
